// File: rtl/vnu_serial.sv
// Serial variable-node update unit for the LDPC decoder.
// Takes one channel LLR followed by DEG check-to-variable messages (sign-magnitude),
// then emits DEG extrinsic messages sat(total - msg[k]) and a hard decision.
// Optional build macro VNU_SAT_STATS_EN adds a sticky saturation counter port sat_count.
module vnu_serial #(
  parameter int WIDTH = 6,
  parameter int DEG   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [WIDTH-1:0] in_mag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sign,
  output logic [WIDTH-1:0] out_mag,
  output logic             out_last,
  output logic             hard_valid,
  output logic             hard_dec
`ifdef VNU_SAT_STATS_EN
  ,
  output logic [15:0]      sat_count
`endif
);

  // Accumulator wide enough for DEG+1 full-scale terms plus sign: never overflows.
  localparam int SUM_W = WIDTH + 2 + $clog2(DEG + 1);
  localparam int IDX_W = $clog2(DEG);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEG - 1);
  localparam logic [SUM_W-1:0] MAG_MAX  = SUM_W'((1 << WIDTH) - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, SUM, EMIT} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [SUM_W-1:0] total_q;
  logic [SUM_W-1:0] msg_q [DEG];
  logic             out_valid_q, out_sign_q, out_last_q;
  logic [WIDTH-1:0] out_mag_q;
  logic             hard_valid_q, hard_dec_q;

  logic             in_fire, out_fire;
  logic [SUM_W-1:0] in_tc;
  logic [IDX_W-1:0] idx_inc, sel;
  logic [SUM_W-1:0] diff, diff_abs;
  logic             res_sign, res_sat;
  logic [WIDTH-1:0] res_mag;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  // Sign-magnitude to two's complement; negative zero negates to zero on its own.
  always_comb begin
    in_tc = {{(SUM_W-WIDTH){1'b0}}, in_mag};
    if (in_sign) in_tc = ~in_tc + 1'b1;
  end

  // Extrinsic result for the message about to be loaded into the output register.
  always_comb begin
    idx_inc  = idx_q + 1'b1;
    sel      = (state_q == SUM || idx_q == IDX_LAST) ? '0 : idx_inc;
    diff     = total_q - msg_q[sel];
    res_sign = diff[SUM_W-1];
    diff_abs = res_sign ? (~diff + 1'b1) : diff;
    res_sat  = diff_abs > MAG_MAX;
    res_mag  = res_sat ? '1 : diff_abs[WIDTH-1:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and input-side ready.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = COLLECT;
      end
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid && idx_q == IDX_LAST) state_d = SUM;
      end
      SUM:     state_d = EMIT;
      EMIT:    if (out_fire && out_last_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Message store: each check message lands in the slot named by idx_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEG; i++) msg_q[i] <= '0;
    end else if (state_q == COLLECT && in_fire) begin
      for (int i = 0; i < DEG; i++)
        if (idx_q == IDX_W'(i)) msg_q[i] <= in_tc;
    end
  end

  // Accumulator, index and registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      total_q      <= '0;
      out_valid_q  <= 1'b0;
      out_sign_q   <= 1'b0;
      out_mag_q    <= '0;
      out_last_q   <= 1'b0;
      hard_valid_q <= 1'b0;
      hard_dec_q   <= 1'b0;
    end else begin
      hard_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (in_fire) begin
          total_q <= in_tc;
          idx_q   <= '0;
        end
        COLLECT: if (in_fire) begin
          total_q <= total_q + in_tc;
          idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_inc;
        end
        SUM: begin
          out_valid_q  <= 1'b1;
          out_sign_q   <= res_sign;
          out_mag_q    <= res_mag;
          out_last_q   <= 1'b0;
          hard_dec_q   <= total_q[SUM_W-1];
          hard_valid_q <= 1'b1;
          idx_q        <= '0;
        end
        EMIT: if (out_fire) begin
          if (out_last_q) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            idx_q       <= '0;
          end else begin
            idx_q      <= idx_inc;
            out_sign_q <= res_sign;
            out_mag_q  <= res_mag;
            out_last_q <= (idx_inc == IDX_LAST);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sign   = out_sign_q;
  assign out_mag    = out_mag_q;
  assign out_last   = out_last_q;
  assign hard_valid = hard_valid_q;
  assign hard_dec   = hard_dec_q;

`ifdef VNU_SAT_STATS_EN
  logic        out_sat_q;
  logic [15:0] sat_count_q;

  // Remember whether the held output clipped; count it when it is handed off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sat_q   <= 1'b0;
      sat_count_q <= '0;
    end else begin
      if (state_q == SUM || (state_q == EMIT && out_fire && !out_last_q))
        out_sat_q <= res_sat;
      if (out_fire && out_sat_q && sat_count_q != 16'hFFFF)
        sat_count_q <= sat_count_q + 1'b1;
    end
  end

  assign sat_count = sat_count_q;
`endif

endmodule

// File: tb/tb_vnu_serial.sv
// Randomized, self-checking bench for vnu_serial with an arithmetic reference model
// and an output scoreboard checked on every handshake.
module tb_vnu_serial;
  localparam int W    = 6;
  localparam int DEG  = 3;
  localparam int MAXM = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_sign = 1'b0;
  logic [W-1:0] in_mag = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_sign;
  logic [W-1:0] out_mag;
  logic         out_last;
  logic         hard_valid;
  logic         hard_dec;
`ifdef VNU_SAT_STATS_EN
  logic [15:0]  sat_count;
`endif

  vnu_serial #(.WIDTH(W), .DEG(DEG)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_mag     (in_mag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sign   (out_sign),
    .out_mag    (out_mag),
    .out_last   (out_last),
    .hard_valid (hard_valid),
    .hard_dec   (hard_dec)
`ifdef VNU_SAT_STATS_EN
    ,
    .sat_count  (sat_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         s;
    logic [W-1:0] m;
    logic         l;
    logic         sat;
  } exp_t;

  exp_t exp_q [$];
  bit   hard_q [$];
  exp_t e_mon;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  int llr_cyc = 0;
  int exp_sat = 0;
  int ready_mode = 0;
  int wait_cnt = 0;

  logic         ns [DEG];
  logic [W-1:0] nm [DEG];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // out_ready pattern: 0 = always ready, 1 = stall each output, 2 = random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: begin
        if (out_ready) begin
          out_ready = 1'b0;
          wait_cnt  = 0;
        end else if (out_valid) begin
          wait_cnt++;
          if (wait_cnt > 3) out_ready = 1'b1;
        end
      end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor at the falling edge: values here are what the next rising edge sees.
  logic         prev_stall = 1'b0;
  logic         prev_valid = 1'b0;
  logic         prev_s = 1'b0;
  logic         prev_l = 1'b0;
  logic [W-1:0] prev_m = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_sign", out_sign, prev_s);
        check_eq("hold_mag", out_mag, prev_m);
        check_eq("hold_last", out_last, prev_l);
      end
      if (out_valid && !prev_valid)
        check_eq("latency", cyc - last_acc_cyc, 1);
      if (out_valid)
        check_eq("in_ready_busy", in_ready, 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", exp_q.size(), 1);
        end else begin
          e_mon = exp_q.pop_front();
          check_eq("out_sign", out_sign, e_mon.s);
          check_eq("out_mag", out_mag, e_mon.m);
          check_eq("out_last", out_last, e_mon.l);
          if (e_mon.sat && exp_sat < 65535) exp_sat++;
        end
      end
      if (hard_valid) begin
        if (hard_q.size() == 0) check_eq("spurious_hard", hard_q.size(), 1);
        else check_eq("hard_dec", hard_dec, hard_q.pop_front());
      end
      prev_stall = out_valid && !out_ready;
      prev_valid = out_valid;
      prev_s = out_sign;
      prev_m = out_mag;
      prev_l = out_last;
    end
  end

  task automatic send_beat(input logic s, input logic [W-1:0] m, input bit is_msg);
    int t = 0;
    in_valid = 1'b1;
    in_sign  = s;
    in_mag   = m;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) check_eq("in_accept_timeout", in_ready, 1);
    @(posedge clk); #1;
    if (is_msg) last_acc_cyc = cyc;
    else        llr_cyc = cyc;
    in_valid = 1'b0;
    in_sign  = 1'b0;
    in_mag   = '0;
  endtask

  // Reference: total = LLR + sum(msgs); each output is total minus its own message.
  task automatic run_node(input logic ls, input logic [W-1:0] lm);
    int   total, v, r, a;
    exp_t e;
    total = ls ? -int'(lm) : int'(lm);
    for (int k = 0; k < DEG; k++) total += ns[k] ? -int'(nm[k]) : int'(nm[k]);
    hard_q.push_back(total < 0);
    for (int k = 0; k < DEG; k++) begin
      v = ns[k] ? -int'(nm[k]) : int'(nm[k]);
      r = total - v;
      a = (r < 0) ? -r : r;
      e.s   = (r < 0);
      e.m   = W'((a > MAXM) ? MAXM : a);
      e.l   = (k == DEG - 1);
      e.sat = (a > MAXM);
      exp_q.push_back(e);
    end
    send_beat(ls, lm, 1'b0);
    for (int k = 0; k < DEG; k++) send_beat(ns[k], nm[k], 1'b1);
  endtask

  task automatic set_msgs(input logic s0, input int m0, input logic s1, input int m1,
                          input logic s2, input int m2);
    ns[0] = s0; nm[0] = W'(m0);
    ns[1] = s1; nm[1] = W'(m1);
    ns[2] = s2; nm[2] = W'(m2);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || hard_q.size() != 0) && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq("drain_pending", exp_q.size() + hard_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int c1, t;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_sign", out_sign, 0);
    check_eq("rst_out_mag", out_mag, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_hard_valid", hard_valid, 0);
    check_eq("rst_hard_dec", hard_dec, 0);
`ifdef VNU_SAT_STATS_EN
    check_eq("rst_sat_count", sat_count, 0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed nodes, always ready, applied back-to-back.
    ready_mode = 0;
    set_msgs(0, 5, 1, 3, 0, 20);   run_node(0, 10);
    c1 = llr_cyc;
    set_msgs(1, 1, 1, 2, 1, 3);    run_node(1, 40);
    check_eq("node_period", llr_cyc - c1, 2 * DEG + 2);
    set_msgs(0, 63, 0, 63, 0, 63); run_node(0, 63);
    set_msgs(1, 7, 1, 0, 0, 0);    run_node(0, 7);
    drain();
`ifdef VNU_SAT_STATS_EN
    check_eq("sat_count_directed", sat_count, exp_sat);
`endif

    // Backpressure with a back-to-back follower.
    ready_mode = 1;
    set_msgs(0, 5, 1, 3, 0, 20);   run_node(0, 10);
    set_msgs(1, 1, 1, 2, 1, 3);    run_node(1, 40);
    drain();

    // Randomized nodes with random downstream readiness.
    ready_mode = 2;
    for (int n = 0; n < 24; n++) begin
      bit big;
      big = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < DEG; k++) begin
        ns[k] = 1'($urandom_range(0, 1));
        nm[k] = big ? W'($urandom_range(40, MAXM)) : W'($urandom_range(0, MAXM));
      end
      run_node(1'($urandom_range(0, 1)), W'($urandom_range(0, MAXM)));
    end
    drain();

    // Reset in the middle of EMIT, after the first output handshake.
    ready_mode = 0;
    set_msgs(0, 5, 1, 3, 0, 20);   run_node(0, 10);
    t = 0;
    while (exp_q.size() > DEG - 1 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check_eq("mid_reset_one_out", exp_q.size(), DEG - 1);
    check_eq("mid_reset_in_emit", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_reset_out_valid", out_valid, 0);
    check_eq("mid_reset_in_ready", in_ready, 1);
    check_eq("mid_reset_out_last", out_last, 0);
    exp_q.delete();
    hard_q.delete();
    exp_sat = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_eq("post_reset_in_ready", in_ready, 1);
    set_msgs(0, 5, 1, 3, 0, 20);   run_node(0, 10);
    set_msgs(0, 63, 0, 63, 0, 63); run_node(0, 63);
    drain();
`ifdef VNU_SAT_STATS_EN
    check_eq("sat_count_final", sat_count, exp_sat);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
